// File: rtl/instr_reg.sv
// Instruction register and operand-field extractor for the esc64 datapath.
// Optional fetch timeout is enabled by defining INSTR_REG_TIMEOUT_EN.
module instr_reg #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] data,
  input  logic        ir_load,
  input  logic        mem_ack,
  input  logic        flush,
  output logic        mem_req,
  output logic        ir_valid,
  output logic [6:0]  opcode,
  output logic [2:0]  op0,
  output logic [2:0]  op1,
  output logic [2:0]  op2,
  output logic [15:0] imm,
  output logic        fetch_err
);

  typedef enum logic [1:0] {IDLE, WAIT_INSTR, WAIT_IMM} state_t;

  state_t      state;
  logic [15:0] ir;
  logic        timeout;

  assign opcode = ir[15:9];
  assign op0    = ir[8:6];
  assign op1    = ir[5:3];
  assign op2    = ir[2:0];

`ifdef INSTR_REG_TIMEOUT_EN
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wait_cnt;

  // Fires on the wait cycle whose increment would reach TIMEOUT_CYCLES.
  assign timeout = (state != IDLE) && !mem_ack && (wait_cnt == WAIT_LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt  <= '0;
      fetch_err <= 1'b0;
    end else if (flush) begin
      wait_cnt  <= '0;
      fetch_err <= 1'b0;
    end else if (state == IDLE) begin
      wait_cnt <= '0;
      if (ir_load) fetch_err <= 1'b0;
    end else if (mem_ack) begin
      wait_cnt <= '0;
    end else if (timeout) begin
      wait_cnt  <= '0;
      fetch_err <= 1'b1;
    end else begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign timeout   = 1'b0;
  // Always 0 across the legal parameter range.
  assign fetch_err = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ir       <= '0;
      imm      <= '0;
      ir_valid <= 1'b0;
      mem_req  <= 1'b0;
    end else if (flush) begin
      state    <= IDLE;
      ir_valid <= 1'b0;
      mem_req  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ir_load) begin
            state    <= WAIT_INSTR;
            ir_valid <= 1'b0;
            mem_req  <= 1'b1;
          end
        end
        WAIT_INSTR: begin
          if (mem_ack) begin
            ir <= data;
            if (data[15]) begin
              state <= WAIT_IMM;
            end else begin
              imm      <= '0;
              ir_valid <= 1'b1;
              mem_req  <= 1'b0;
              state    <= IDLE;
            end
          end else if (timeout) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end
        end
        WAIT_IMM: begin
          if (mem_ack) begin
            imm      <= data;
            ir_valid <= 1'b1;
            mem_req  <= 1'b0;
            state    <= IDLE;
          end else if (timeout) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
